alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Issue stage directly upstream of the ALU. Decodes RV32I OP/OP-IMM/LUI/AUIPC fields into the 4-bit ALU ctl code.
//  Selects and conditions operands a/b, then registers them behind a 2-entry valid/ready skid buffer.
//  Decouples decode from execute so back-pressure never drops or duplicates an op. Registered output; 1-cycle latency.
// PARAMETERS
//  DATA_WIDTH  32  operand/immediate/pc width (>=8)
//  RD_WIDTH    5   destination register index width
// PORTS
//  clk         in   1           single clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  flush       in   1           kill all buffered ops (sync)
//  in_valid    in   1           decoded op offered
//  in_ready    out  1           stage can accept op this cycle
//  opcode      in   7           instr[6:0]
//  funct3      in   3           instr[14:12]
//  funct7_5    in   1           instr[30]
//  rd_in       in   RD_WIDTH    destination register
//  rs1_data    in   DATA_WIDTH  register operand 1
//  rs2_data    in   DATA_WIDTH  register operand 2
//  imm         in   DATA_WIDTH  sign-extended immediate (U-type already <<12)
//  pc          in   DATA_WIDTH  instruction pc
//  out_valid   out  1           alu_* outputs hold a valid op
//  out_ready   in   1           ALU/downstream consumes op
//  alu_a       out  DATA_WIDTH  ALU operand a
//  alu_b       out  DATA_WIDTH  ALU operand b
//  alu_ctl     out  4           ALU op code
//  rd_out      out  RD_WIDTH    destination register
//  illegal     out  1           op not executable by ALU
// BEHAVIOUR
//  Reset (async, rst_n=0): both entries empty. out_valid=0, in_ready=1. alu_a=alu_b=0, alu_ctl=0, rd_out=0, illegal=0.
//  ctl codes: AND=0 OR=1 XOR=2 ADD=3 SUB=4 SLL=5 SRL=6 SRA=7 SLT=8. Unsupported ops use ctl 4'hF (ALU yields 0).
//  OP (0110011): a=rs1, b=rs2.
//    f3 000: ADD if f7_5=0, else SUB.  001: SLL.  010: SLT.  100: XOR.
//    101: SRL if f7_5=0, else SRA.  110: OR.  111: AND.
//  OP-IMM (0010011): a=rs1, b=imm, same f3 map. f3=000 is always ADD (f7_5 ignored). f3=101 uses f7_5 for SRAI.
//  LUI (0110111): a=0, b=imm, ctl=ADD.  AUIPC (0010111): a=pc, b=imm, ctl=ADD.
//  Shifts (ctl 5/6/7): b forced to {0, b[4:0]}; upper bits zeroed, because the ALU shifts by full b.
//  Illegal: f3=011 (SLTU) on OP/OP-IMM, or any other opcode.
//    illegal=1, ctl=4'hF, a=b=0. Still flows through the handshake like a normal op.
//  Handshake: accept when in_valid&in_ready; emit when out_valid&out_ready. Both may occur in the same cycle.
//  Storage: main reg drives outputs; skid reg catches an op accepted while main is held (out_valid&~out_ready).
//  in_ready = ~skid_full, registered; no combinational path from out_ready.
//  Transitions:
//    EMPTY: accept -> ONE.
//    ONE: accept&~emit -> FULL. emit&~accept -> EMPTY. accept&emit -> ONE (new op).
//    FULL: emit -> ONE (skid moves to main). in_ready=0, so no accept.
//  Ordering strictly FIFO. Outputs stable while out_valid&~out_ready.
//  Latency: op accepted at edge N is visible on outputs after edge N (same-cycle visibility when buffer was EMPTY, or ONE with emit).
//  flush: next edge -> EMPTY. The in_valid op in the flush cycle is discarded. Data regs may keep stale values; out_valid=0.
//  Reset asserted mid-operation: immediate EMPTY, no partial op emitted after release.
//  Widths: all operand paths DATA_WIDTH; no arithmetic in this stage.
// TESTING
//  OP f3=000 f7_5=1, rs1=10, rs2=3, out_ready=1 -> next cycle ctl=4, a=10, b=3, out_valid=1.
//  OP-IMM f3=101 f7_5=1, rs1=32'h8000_0000, imm=32'h0000_0424 -> ctl=7, b=32'h4.
//  AUIPC pc=32'h100, imm=32'h1000 -> a=32'h100, b=32'h1000, ctl=3.
//    LUI imm=32'hABCDE000 -> a=0, b=32'hABCDE000.
//  Backpressure: out_ready=0, 3 back-to-back ops A,B,C -> A held, B in skid, in_ready=0, C stalled.
//    out_ready=1 -> A,B,C emitted in order, no loss or duplication.
//  flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed op never appears.
//  OP f3=011, then opcode 1100011 -> illegal=1, ctl=4'hF, a=b=0.
//    rst_n pulsed low while FULL -> out_valid=0, in_ready=1 asynchronously.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Op handshake between decode and the ALU issue stage, plus the registered operand bus towards the ALU.
// The slave side is the issue stage; the master side is decode and the ALU together.
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [RD_WIDTH-1:0]   rd_in;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_ctl;
    logic [RD_WIDTH-1:0]   rd_out;
    logic                  illegal;

    modport master (
        output flush, in_valid, opcode, funct3, funct7_5, rd_in,
               rs1_data, rs2_data, imm, pc, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctl, rd_out, illegal
    );

    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5, rd_in,
               rs1_data, rs2_data, imm, pc, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctl, rd_out, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Purpose: decode RV32I OP/OP-IMM/LUI/AUIPC into ALU ctl plus conditioned operands, held in a 2-entry skid buffer.
// Latency: 1 cycle, registered outputs.
// Backpressure: a skid entry absorbs one op while the output is held; in_ready is registered (~skid full).
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_XOR = 4'd2;
    localparam logic [3:0] CTL_ADD = 4'd3;
    localparam logic [3:0] CTL_SUB = 4'd4;
    localparam logic [3:0] CTL_SLL = 4'd5;
    localparam logic [3:0] CTL_SRL = 4'd6;
    localparam logic [3:0] CTL_SRA = 4'd7;
    localparam logic [3:0] CTL_SLT = 4'd8;
    localparam logic [3:0] CTL_NOP = 4'hF;

    typedef struct packed {
        logic                  illegal;
        logic [3:0]            ctl;
        logic [RD_WIDTH-1:0]   rd;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } op_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    op_t                   dec, main_q, skid_q;
    logic [3:0]            ctl_raw;
    logic [DATA_WIDTH-1:0] b_raw;
    state_t                state_q, state_d;
    logic                  accept, emit;
    logic                  ld_main_in, ld_main_skid, ld_skid;

    always_comb begin
        dec         = '0;
        dec.rd      = bus.rd_in;
        dec.illegal = 1'b1;
        dec.ctl     = CTL_NOP;
        ctl_raw     = CTL_NOP;
        b_raw       = '0;
        case (bus.opcode)
            OPC_OP, OPC_OPIMM: begin
                b_raw = (bus.opcode == OPC_OP) ? bus.rs2_data : bus.imm;
                case (bus.funct3)
                    3'b000:  ctl_raw = (bus.opcode == OPC_OP && bus.funct7_5) ? CTL_SUB : CTL_ADD;
                    3'b001:  ctl_raw = CTL_SLL;
                    3'b010:  ctl_raw = CTL_SLT;
                    3'b100:  ctl_raw = CTL_XOR;
                    3'b101:  ctl_raw = bus.funct7_5 ? CTL_SRA : CTL_SRL;
                    3'b110:  ctl_raw = CTL_OR;
                    3'b111:  ctl_raw = CTL_AND;
                    default: ctl_raw = CTL_NOP;
                endcase
                if (ctl_raw != CTL_NOP) begin
                    dec.illegal = 1'b0;
                    dec.ctl     = ctl_raw;
                    dec.a       = bus.rs1_data;
                    // The ALU shifts by the whole of b, so only the shamt field may survive.
                    dec.b       = (ctl_raw inside {CTL_SLL, CTL_SRL, CTL_SRA})
                                  ? {{(DATA_WIDTH-5){1'b0}}, b_raw[4:0]} : b_raw;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.illegal = 1'b0;
                dec.ctl     = CTL_ADD;
                dec.a       = (bus.opcode == OPC_AUIPC) ? bus.pc : '0;
                dec.b       = bus.imm;
            end
            default: ;
        endcase
    end

    assign accept = bus.in_valid && (state_q != FULL);
    assign emit   = (state_q != EMPTY) && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d    = ONE;
                ld_main_in = 1'b1;
            end
            ONE: begin
                if (accept && emit) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (emit) begin
                state_d      = ONE;
                ld_main_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ld_main_in)   main_q <= dec;
            if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)      skid_q <= dec;
        end
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.alu_a     = main_q.a;
    assign bus.alu_b     = main_q.b;
    assign bus.alu_ctl   = main_q.ctl;
    assign bus.rd_out    = main_q.rd;
    assign bus.illegal   = main_q.illegal;
endmodule
